// File: rtl/arm_encode.sv
// arm_encode: builds ARM data-processing and B/BL instruction words.
// Immediate operands are searched for an 8-bit value with an even rotate.
// Optional macro ARM_ENCODE_FAST_IMM_EN: test all 16 rotations in a single
// SEARCH cycle instead of one rotation per cycle.
module arm_encode (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  cond,
    input  logic        is_branch,
    input  logic        link,
    input  logic [23:0] branch_offset,
    input  logic [3:0]  opcode,
    input  logic        s_bit,
    input  logic [3:0]  rd,
    input  logic [3:0]  rn,
    input  logic [3:0]  rm,
    input  logic [3:0]  rs,
    input  logic [1:0]  op2_kind,
    input  logic [31:0] imm32,
    input  logic [1:0]  shift_type,
    input  logic [4:0]  shift_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, SEARCH, OUT} state_t;

    typedef struct packed {
        logic [3:0]  cond;
        logic        is_branch;
        logic        link;
        logic [23:0] branch_offset;
        logic [3:0]  opcode;
        logic        s_bit;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [3:0]  rs;
        logic [1:0]  op2_kind;
        logic [31:0] imm32;
        logic [1:0]  shift_type;
        logic [4:0]  shift_imm;
    } req_t;

    state_t      state, state_nx;
    req_t        req;
    logic [3:0]  rot, rot_nx;
    logic        err_q, err_nx;
    logic [31:0] rot_val;
    logic        rot_hit;
    logic        accept;
    logic [31:0] word;

    // Rotate left by twice the 4-bit rotation field.
    function automatic logic [31:0] rol2(input logic [31:0] x, input logic [3:0] r);
        logic [63:0] t;
        t = {x, x} << {r, 1'b0};
        return t[63:32];
    endfunction

    assign accept    = in_valid && (state == IDLE);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign err       = (state == OUT) && err_q;

    // Candidate immediate for the current rotation; also yields imm8 in OUT.
    always_comb begin
        rot_val = rol2(req.imm32, rot);
        rot_hit = (rot_val[31:8] == 24'd0);
    end

`ifdef ARM_ENCODE_FAST_IMM_EN
    logic        fast_hit;
    logic [3:0]  fast_rot;
    logic [31:0] fast_t;

    // Priority search over all rotations; scanning downward leaves the lowest match.
    always_comb begin
        fast_hit = 1'b0;
        fast_rot = 4'd0;
        fast_t   = 32'd0;
        for (int i = 15; i >= 0; i--) begin
            fast_t = rol2(req.imm32, 4'(i));
            if (fast_t[31:8] == 24'd0) begin
                fast_hit = 1'b1;
                fast_rot = 4'(i);
            end
        end
    end
`endif

    // State, rotation and error registers; request captured on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rot   <= 4'd0;
            err_q <= 1'b0;
            req   <= '0;
        end else begin
            state <= state_nx;
            rot   <= rot_nx;
            err_q <= err_nx;
            if (accept) begin
                req <= '{cond, is_branch, link, branch_offset, opcode, s_bit,
                         rd, rn, rm, rs, op2_kind, imm32, shift_type, shift_imm};
            end
        end
    end

    // Next-state logic: immediates go through SEARCH, everything else straight to OUT.
    always_comb begin
        state_nx = state;
        rot_nx   = rot;
        err_nx   = err_q;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    rot_nx = 4'd0;
                    err_nx = 1'b0;
                    state_nx = (!is_branch && op2_kind == 2'd0) ? SEARCH : OUT;
                end
            end
            SEARCH: begin
`ifdef ARM_ENCODE_FAST_IMM_EN
                state_nx = OUT;
                rot_nx   = fast_rot;
                err_nx   = !fast_hit;
`else
                if (rot_hit) begin
                    state_nx = OUT;
                end else if (rot == 4'd15) begin
                    state_nx = OUT;
                    err_nx   = 1'b1;
                end else begin
                    rot_nx = rot + 4'd1;
                end
`endif
            end
            OUT: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Instruction assembly from the held request; zero unless presenting a good word.
    always_comb begin
        logic       cmp_op, mov_op;
        logic [11:0] op2;
        cmp_op = (req.opcode[3:2] == 2'b10);
        mov_op = (req.opcode[3:2] == 2'b11) && req.opcode[0];
        unique case (req.op2_kind)
            2'd0: op2 = {rot, rot_val[7:0]};
            2'd1: op2 = {8'h00, req.rm};
            2'd2: op2 = {req.shift_imm, req.shift_type, 1'b0, req.rm};
            default: op2 = {req.rs, 1'b0, req.shift_type, 1'b1, req.rm};
        endcase
        if (req.is_branch)
            word = {req.cond, 3'b101, req.link, req.branch_offset};
        else
            word = {req.cond, 2'b00, (req.op2_kind == 2'd0), req.opcode,
                    req.s_bit | cmp_op, mov_op ? 4'd0 : req.rn,
                    cmp_op ? 4'd0 : req.rd, op2};
        inst = (state == OUT && !err_q) ? word : 32'd0;
    end

endmodule

// File: doc/arm_encode.md
ARM_ENCODE -- requirements
Module: arm_encode

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  request fields valid.
REQ-004 in_ready  output  1  encoder can accept a request.
REQ-005 cond  input  4  condition field, placed at inst[31:28].
REQ-006 is_branch  input  1  1 = B/BL; 0 = data-processing.
REQ-007 link  input  1  L bit for branch.
REQ-008 branch_offset  input  24  signed word offset for branch.
REQ-009 opcode  input  4  data-processing opcode.
REQ-010 s_bit  input  1  set-flags request.
REQ-011 rd, rn, rm, rs  input  4 each  register numbers.
REQ-012 op2_kind  input  2  operand 2 form: 0 immediate, 1 register, 2 register shifted by immediate, 3 register shifted by register.
REQ-013 imm32  input  32  immediate value for op2_kind 0.
REQ-014 shift_type  input  2  LSL/LSR/ASR/ROR code.
REQ-015 shift_imm  input  5  shift amount for op2_kind 2.
REQ-016 out_valid  output  1  encoded word available.
REQ-017 out_ready  input  1  consumer accepts the word.
REQ-018 inst  output  32  encoded instruction.
REQ-019 err  output  1  imm32 not encodable; qualified by out_valid.

Function
REQ-020 FSM states: IDLE, SEARCH, OUT; in_ready SHALL be 1 only in IDLE.
REQ-021 Accept on in_valid && in_ready: all inputs registered; later input changes have no effect.
REQ-022 Branch or op2_kind 1-3: IDLE -> OUT; out_valid high 1 clock after accept.
REQ-023 op2_kind 0: IDLE -> SEARCH with rot=0; each SEARCH cycle tests one rot: found if imm32 ROL (2*rot) < 256.
REQ-024 Lowest matching rot wins; on match -> OUT with inst[11:8]=rot, inst[7:0]=imm32 ROL (2*rot), inst[25]=1; out_valid at clock r+2 after accept.
REQ-025 No match at rot=15 -> OUT with err=1, inst=0 (clock 17 after accept).
REQ-026 DP layout: [31:28]cond, [27:26]00, [25]I, [24:21]opcode, [20]S, [19:16]rn, [15:12]rd, [11:0]operand 2.
REQ-027 Opcodes 8-B (TST/TEQ/CMP/CMN): S forced 1, rd field 0; opcodes D,F (MOV/MVN): rn field 0.
REQ-028 op2_kind 1: [11:0]={8'h00, rm}; kind 2: {shift_imm, shift_type, 0, rm}; kind 3: {rs, 0, shift_type, 1, rm}.
REQ-029 Branch: [31:28]cond, [27:25]101, [24]link, [23:0]branch_offset; err=0.
REQ-030 OUT: inst/err held stable while out_valid && !out_ready; on out_ready -> IDLE, out_valid low next clock.
REQ-031 No back-to-back acceptance: a new request is accepted no sooner than the cycle after the OUT handshake.

Reset
REQ-032 reset SHALL force IDLE, out_valid=0, err=0, inst=0, rot=0 on the next edge, including mid-SEARCH or mid-OUT; the pending request is discarded.
REQ-033 in_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-034 Macro ARM_ENCODE_FAST_IMM_EN defined: all 16 rotations tested combinationally in one SEARCH cycle, lowest rot wins, immediate latency fixed at 2 clocks (found or err).
REQ-035 Macro undefined: iterative one-rotation-per-cycle search per REQ-023..025; encoded values identical in both builds.

Verification
REQ-036 ADD R4,R3,R2 (opcode 4, kind 1, cond E) -> inst=E0834002, out_valid 1 clock after accept.
REQ-037 AND R1,R1,#2 -> E2011002 at clock 2; BIC R9,R8,#0xFF00 -> E3C89CFF, rot=C, at clock 14 (clock 2 with ARM_ENCODE_FAST_IMM_EN).
REQ-038 CMP R7,R8 with s_bit=0, rd=5 -> E1570008; MOV R12,R4,ROR R3 (kind 3) -> E1A0C374; MOV R2,R0,LSL #2 -> E1A02100.
REQ-039 BL, offset 0x00000B -> EB00000B, err=0.
REQ-040 imm32=0x00000101 -> err=1, inst=0 at clock 17; out_ready held low 5 clocks -> outputs stable, in_ready=0 throughout.
REQ-041 reset asserted during SEARCH of 0xFF00 -> out_valid=0 and in_ready=1 after reset deasserts; the next request encodes correctly.
